// File: rtl/ram8_arbiter_pkg.sv
// Shared definitions for the two-requester RAM8 front end.
package ram8_arbiter_pkg;

  localparam int unsigned RAM_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; 'last' is the requester served most recently.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = req0 & (~req1 | last);
    gnt1 = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Serialises two requesters onto one RAM8 and zero-fills the RAM after reset.
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned ADDR_W         = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy,
  output logic [WIDTH-1:0]  ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out
);

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                last;
  logic                cmd_we;
  logic                cmd_id;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [WIDTH-1:0]    cmd_wdata;
  logic                arb_gnt0;
  logic                arb_gnt1;

  rr_arbiter2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt0 (arb_gnt0),
    .gnt1 (arb_gnt1)
  );

  // Grants only exist in IDLE and are held off while reset is asserted.
  assign gnt0 = arb_gnt0 & (state == ST_IDLE) & ~reset;
  assign gnt1 = arb_gnt1 & (state == ST_IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      clr_cnt   <= '0;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(RAM_DEPTH - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (arb_gnt0 | arb_gnt1) begin
            cmd_we    <= arb_gnt1 ? we1 : we0;
            cmd_addr  <= arb_gnt1 ? addr1 : addr0;
            cmd_wdata <= arb_gnt1 ? wdata1 : wdata0;
            cmd_id    <= arb_gnt1;
            last      <= arb_gnt1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!cmd_we) rdata <= ram_out;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM pins and status decoded from registered state only; the clear write is masked during reset.
  always_comb begin
    busy     = 1'b0;
    ram_load = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    case (state)
      ST_INIT: begin
        busy     = 1'b1;
        ram_load = ~reset;
        ram_addr = clr_cnt;
      end
      ST_ACCESS: begin
        busy     = 1'b1;
        ram_load = cmd_we;
        ram_addr = cmd_addr;
        ram_in   = cmd_wdata;
      end
      ST_RESP: begin
        busy    = 1'b1;
        rvalid0 = ~cmd_id;
        rvalid1 = cmd_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Randomised self-checking bench for ram8_arbiter against a transaction-level memory model.
module tb_ram8_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fill = 1'b0;

  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [2:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_load;
  logic [15:0] rdata, ram_in, ram_out;
  logic [2:0]  ram_addr;

  logic        req0_b = 0, we0_b = 0, req1_b = 0, we1_b = 0;
  logic [2:0]  addr0_b = 0, addr1_b = 0;
  logic [15:0] wdata0_b = 0, wdata1_b = 0;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b, ram_load_b;
  logic [15:0] rdata_b, ram_in_b, ram_out_b;
  logic [2:0]  ram_addr_b;

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [15:0] seed_a [8];
  logic [15:0] seed_b [8];

  logic [15:0] exp_mem [8];
  logic [15:0] exp_rdata;
  int          last_winner;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ram8_arbiter #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  ram8_arbiter #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .busy(busy_b), .ram_in(ram_in_b), .ram_addr(ram_addr_b), .ram_load(ram_load_b),
    .ram_out(ram_out_b)
  );

  // RAM8 stand-ins: synchronous write, combinational read, preloadable with garbage.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] <= seed_a[i];
        mem_b[i] <= seed_b[i];
      end
    end else begin
      if (ram_load) mem_a[ram_addr] <= ram_in;
      if (ram_load_b) mem_b[ram_addr_b] <= ram_in_b;
    end
  end
  assign ram_out   = mem_a[ram_addr];
  assign ram_out_b = mem_b[ram_addr_b];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
    exp_rdata   = 16'h0000;
    last_winner = 1;
  endtask

  // One command from requester r; checks grant, ACCESS pins, RESP pulse and data.
  task automatic run_cmd(input int r, input logic w, input logic [2:0] a, input logic [15:0] d,
                         output int waited);
    logic g;
    if (r == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    waited = 0;
    #1;
    g = (r == 0) ? gnt0 : gnt1;
    while (!g && waited < 40) begin
      @(posedge clk); #2;
      waited++;
      g = (r == 0) ? gnt0 : gnt1;
    end
    n_cmp++;
    if (!g || (gnt0 & gnt1)) begin
      n_err++;
      $display("FAIL grant req%0d: gnt0=%b gnt1=%b after %0d cycles, required only gnt%0d=1", r, gnt0, gnt1, waited, r);
      req0 = 0; req1 = 0;
      return;
    end
    @(posedge clk); #1;
    if (r == 0) req0 = 0; else req1 = 0;
    n_cmp++;
    if ({busy, ram_load, ram_addr, rvalid0, rvalid1} !== {1'b1, w, a, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL access: busy=%b load=%b addr=%0d rv=%b%b, required busy=1 load=%b addr=%0d rv=00",
               busy, ram_load, ram_addr, rvalid0, rvalid1, w, a);
    end
    if (w) begin
      n_cmp++;
      if (ram_in !== d) begin
        n_err++;
        $display("FAIL access_wdata: ram_in=%h, required %h", ram_in, d);
      end
    end
    @(posedge clk); #1;
    if (!w) exp_rdata = exp_mem[a];
    n_cmp++;
    if ({rvalid0, rvalid1, ram_load} !== {r == 0, r == 1, 1'b0}) begin
      n_err++;
      $display("FAIL resp req%0d: rvalid0=%b rvalid1=%b load=%b, required rvalid%0d only, load=0",
               r, rvalid0, rvalid1, ram_load, r);
    end
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL rdata req%0d addr %0d we=%b: got %h, required %h", r, a, w, rdata, exp_rdata);
    end
    if (w) exp_mem[a] = d;
    last_winner = r;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, rvalid0, rvalid1} !== 3'b000) begin
      n_err++;
      $display("FAIL back_to_idle: busy=%b rv=%b%b, required 0 00", busy, rvalid0, rvalid1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      seed_a[i] = 16'($urandom) | 16'h0001;
      seed_b[i] = 16'($urandom);
    end
    reset = 1; fill = 1;
    @(posedge clk); @(posedge clk); #1;
    fill = 0;
    req0 = 1; req0_b = 1;
    #1;
    n_cmp++;
    if ({busy, ram_load, ram_addr, ram_in, gnt0, gnt1, rvalid0, rvalid1, rdata} !==
        {1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_a: busy=%b load=%b addr=%0d in=%h gnt=%b%b rv=%b%b rdata=%h, required 1 0 0 0 00 00 0",
               busy, ram_load, ram_addr, ram_in, gnt0, gnt1, rvalid0, rvalid1, rdata);
    end
    n_cmp++;
    if ({busy_b, gnt0_b, ram_load_b, rvalid0_b, rdata_b} !== {1'b0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_b: busy=%b gnt0=%b load=%b rv0=%b rdata=%h, required 0 0 0 0 0",
               busy_b, gnt0_b, ram_load_b, rvalid0_b, rdata_b);
    end
    req0 = 0; req0_b = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // Zero-fill sequence, with requester 1 raising a read of addr 5 on the third INIT cycle.
  task automatic test_init_request();
    int waited;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({busy, ram_load, ram_addr, ram_in, gnt0, gnt1} !== {1'b1, 1'b1, 3'(k), 16'h0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL init_cycle %0d: busy=%b load=%b addr=%0d in=%h gnt=%b%b, required 1 1 %0d 0 00",
                 k, busy, ram_load, ram_addr, ram_in, gnt0, gnt1, k);
      end
      if (k == 2) begin req1 = 1; we1 = 0; addr1 = 3'd5; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({busy, gnt1} !== 2'b01) begin
      n_err++;
      $display("FAIL init_done: busy=%b gnt1=%b, required busy=0 gnt1=1", busy, gnt1);
    end
    run_cmd(1, 1'b0, 3'd5, 16'h0, waited);
    n_cmp++;
    if (waited !== 0 || rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL init_read5: waited=%0d rdata=%h, required 0 and 0000", waited, rdata);
    end
  endtask

  task automatic test_write_read();
    int waited;
    run_cmd(0, 1'b1, 3'd3, 16'hBEEF, waited);
    run_cmd(1, 1'b0, 3'd3, 16'h0, waited);
    n_cmp++;
    if (rdata !== 16'hBEEF || waited !== 0) begin
      n_err++;
      $display("FAIL write_then_read: rdata=%h waited=%0d, required BEEF and 0", rdata, waited);
    end
  endtask

  task automatic test_fairness();
    int waited, exp_win, order;
    run_cmd(0, 1'b1, 3'd1, 16'($urandom), waited);
    run_cmd(1, 1'b1, 3'd2, 16'($urandom), waited);
    req0 = 1; we0 = 0; addr0 = 3'd1;
    req1 = 1; we1 = 0; addr1 = 3'd2;
    order = 0;
    for (int i = 0; i < 4; i++) begin
      exp_win = (last_winner == 1) ? 0 : 1;
      waited = 0;
      #1;
      while (!(gnt0 | gnt1) && waited < 10) begin @(posedge clk); #2; waited++; end
      n_cmp++;
      if ({gnt0, gnt1} !== {exp_win == 0, exp_win == 1}) begin
        n_err++;
        $display("FAIL fair_grant %0d: gnt0=%b gnt1=%b, required gnt%0d only", i, gnt0, gnt1, exp_win);
      end
      order = order * 10 + (gnt1 ? 1 : 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++;
      if ({rvalid0, rvalid1} !== {exp_win == 0, exp_win == 1} || rdata !== exp_mem[exp_win == 1 ? 2 : 1]) begin
        n_err++;
        $display("FAIL fair_resp %0d: rv=%b%b rdata=%h, required rvalid%0d rdata=%h",
                 i, rvalid0, rvalid1, rdata, exp_win, exp_mem[exp_win == 1 ? 2 : 1]);
      end
      exp_rdata   = exp_mem[exp_win == 1 ? 2 : 1];
      last_winner = exp_win;
      @(posedge clk); #1;
    end
    req0 = 0; req1 = 0;
    n_cmp++;
    if (order !== 101) begin
      n_err++;
      $display("FAIL fair_order: order=%04d, required 0101", order);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int waited, r;
    logic w;
    logic [2:0] a;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 1));
      w = 1'($urandom);
      a = 3'($urandom_range(0, 7));
      run_cmd(r, w, a, 16'($urandom), waited);
      n_cmp++;
      if (waited !== 0) begin
        n_err++;
        $display("FAIL random_latency %0d: waited=%0d cycles, required 0", i, waited);
      end
    end
  endtask

  task automatic test_reset_abort();
    int waited, any_rv;
    req0 = 1; we0 = 1; addr0 = 3'd6; wdata0 = 16'h1234;
    waited = 0;
    #1;
    while (!gnt0 && waited < 10) begin @(posedge clk); #2; waited++; end
    @(posedge clk); #1;
    n_cmp++;
    if (ram_load !== 1'b1) begin
      n_err++;
      $display("FAIL abort_access: ram_load=%b, required 1", ram_load);
    end
    #2;
    reset = 1;
    #1;
    n_cmp++;
    if ({ram_load, ram_addr, ram_in, rvalid0, rvalid1, gnt0, gnt1, rdata} !== 38'h0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reset: load=%b addr=%0d in=%h rv=%b%b gnt=%b%b rdata=%h busy=%b, required all 0, busy=1",
               ram_load, ram_addr, ram_in, rvalid0, rvalid1, gnt0, gnt1, rdata, busy);
    end
    req0 = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    any_rv = 0;
    for (int k = 0; k < 8; k++) begin
      if (rvalid0 | rvalid1) any_rv++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (any_rv !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reinit: rvalid cycles=%0d busy=%b, required 0 and 0", any_rv, busy);
    end
    run_cmd(0, 1'b0, 3'd6, 16'h0, waited);
  endtask

  task automatic test_no_clear();
    logic [2:0] a;
    a = 3'($urandom_range(0, 7));
    reset = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL noclear_reset_busy: busy=%b, required 0", busy_b);
    end
    reset = 0;
    req0_b = 1; we0_b = 0; addr0_b = a;
    #1;
    n_cmp++;
    if ({gnt0_b, gnt1_b, busy_b} !== 3'b100) begin
      n_err++;
      $display("FAIL noclear_first_grant: gnt=%b%b busy=%b, required 10 0", gnt0_b, gnt1_b, busy_b);
    end
    @(posedge clk); #1;
    req0_b = 0;
    n_cmp++;
    if ({busy_b, ram_load_b, ram_addr_b} !== {1'b1, 1'b0, a}) begin
      n_err++;
      $display("FAIL noclear_access: busy=%b load=%b addr=%0d, required 1 0 %0d", busy_b, ram_load_b, ram_addr_b, a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rvalid0_b, rvalid1_b} !== 2'b10 || rdata_b !== seed_b[a]) begin
      n_err++;
      $display("FAIL noclear_resp: rv=%b%b rdata=%h, required 10 %h", rvalid0_b, rvalid1_b, rdata_b, seed_b[a]);
    end
  endtask

  initial begin
    test_reset();
    test_init_request();
    test_write_read();
    test_fairness();
    test_random();
    test_reset_abort();
    test_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
